// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access size codes and FSM states.
package dmem_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_lane_sel.sv
// Byte-lane steering for sub-word accesses: write enables, replicated store data,
// right-justified load extract and alignment check.
module dmem_lane_sel
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_sh_o,
    output logic [31:0] rdata_ext_o,
    output logic        misalign_o
);

    always_comb begin
        be_o        = 4'b0000;
        wdata_sh_o  = '0;
        rdata_ext_o = '0;
        misalign_o  = 1'b0;
        case (size_i)
            SZ_B: begin
                be_o        = 4'b0001 << addr_lo_i;
                // Replicating the data lets the byte enable alone pick the lane.
                wdata_sh_o  = {4{wdata_i[7:0]}};
                rdata_ext_o = {24'd0, rdata_word_i[{addr_lo_i, 3'b000} +: 8]};
            end
            SZ_H: begin
                be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_sh_o  = {2{wdata_i[15:0]}};
                rdata_ext_o = {16'd0, addr_lo_i[1] ? rdata_word_i[31:16] : rdata_word_i[15:0]};
                misalign_o  = addr_lo_i[0];
            end
            SZ_W: begin
                be_o        = 4'b1111;
                wdata_sh_o  = wdata_i;
                rdata_ext_o = rdata_word_i;
                misalign_o  = (addr_lo_i != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder over a byte-enabled word array with
// synchronous read; one request every three cycles (IDLE, ACCESS, RESP).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e      state_q, state_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rword_q;
    logic [31:0] mem_q [DEPTH];

    logic [3:0]    be;
    logic [31:0]   wdata_sh;
    logic [31:0]   rdata_ext;
    logic          misalign;
    logic          out_of_range;
    logic          illegal;
    logic [AW-1:0] idx;

    assign idx          = addr_q[AW+1:2];
    assign out_of_range = |addr_q[31:AW+2];
    assign illegal      = misalign | out_of_range | (size_q == SZ_ILL);

    dmem_lane_sel u_lane_sel (
        .size_i       (size_q),
        .addr_lo_i    (addr_q[1:0]),
        .wdata_i      (wdata_q),
        .rdata_word_i (rword_q),
        .be_o         (be),
        .wdata_sh_o   (wdata_sh),
        .rdata_ext_o  (rdata_ext),
        .misalign_o   (misalign)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req_valid) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   if (rsp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req_valid) begin
                we_q    <= req_we;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == StAccess) begin
                err_q <= illegal;
            end
        end
    end

    // Storage is deliberately not reset; an async reset forces state_q out of
    // StAccess, which suppresses a pending write.
    always_ff @(posedge clk) begin
        if (state_q == StAccess) begin
            rword_q <= mem_q[idx];
            if (we_q && !illegal) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = reset && (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? rdata_ext : 32'd0;

endmodule
